// File: rtl/sram_ctrl_pkg.sv
// Shared types and macro constants for the SRAM request controller and its response FIFO.
package sram_ctrl_pkg;

  localparam int SRAM_BANK_AW = 10;
  localparam int SRAM_DATA_W  = 32;

  typedef struct packed {
    logic [SRAM_DATA_W-1:0] rdata;
    logic                   err;
    logic                   write;
  } sram_rsp_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO of sram_rsp_t; head entry is presented combinationally on pop_data.
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  sram_rsp_t        push_data,
  input  logic             pop,
  output sram_rsp_t        pop_data,
  output logic             full,
  output logic             empty,
  output logic [OCC_W-1:0] occ
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sram_rsp_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (occ == '0);
  assign full     = (occ == OCC_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_next(wr_ptr);
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occ and the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sram_req_ctrl.sv
// Valid/ready front-end for NUM_BANKS 1024x32 SRAM macros with in-order response FIFO.
// Define SRAM_REQ_CTRL_WRITE_ACK_EN to return a write-ack response (RSP_WRITE=1) per accepted write.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int BANK_AW   = SRAM_BANK_AW,
  parameter int DATA_W    = SRAM_DATA_W,
  parameter int ADDR_W    = BANK_AW + ((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1),
  parameter int RSP_DEPTH = 3
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        REQ_VALID,
  output logic                        REQ_READY,
  input  logic                        REQ_WE,
  input  logic [ADDR_W-1:0]           REQ_ADDR,
  input  logic [DATA_W-1:0]           REQ_BM,
  input  logic [DATA_W-1:0]           REQ_WDATA,
  output logic                        RSP_VALID,
  input  logic                        RSP_READY,
  output logic [DATA_W-1:0]           RSP_RDATA,
  output logic                        RSP_ERR,
  output logic                        RSP_WRITE,
  output logic [BANK_AW-1:0]          MEM_ADDR,
  output logic [DATA_W-1:0]           MEM_DIN,
  output logic [DATA_W-1:0]           MEM_BM,
  output logic                        MEM_WEN,
  output logic                        MEM_REN,
  output logic [NUM_BANKS-1:0]        MEM_MEN,
  input  logic [NUM_BANKS*DATA_W-1:0] MEM_DOUT
);

  localparam int BANK_SW = ADDR_W - BANK_AW;
  localparam int OCC_W   = $clog2(RSP_DEPTH + 1);
  localparam logic [BANK_SW:0] NUM_BANKS_V = NUM_BANKS[BANK_SW:0];
  localparam logic [OCC_W:0]   DEPTH_V     = RSP_DEPTH[OCC_W:0];

  logic [BANK_SW-1:0] bank;
  logic [BANK_SW-1:0] pend_bank;
  logic               in_range;
  logic               accept;
  logic               rsp_accept;
  logic               inflight;
  logic               pend_err;
  logic               pend_write;
  logic [DATA_W-1:0]  bank_dout;
  logic [OCC_W-1:0]   occ;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  sram_rsp_t          push_rsp;
  sram_rsp_t          head;

  assign bank     = REQ_ADDR[ADDR_W-1:BANK_AW];
  assign in_range = ({1'b0, bank} < NUM_BANKS_V);

  // Slot accounting uses registered state only, so a same-cycle pop never opens a slot.
  assign REQ_READY = !RST && (({1'b0, occ} + {{OCC_W{1'b0}}, inflight}) < DEPTH_V);
  assign accept    = REQ_VALID && REQ_READY;

  assign MEM_ADDR = REQ_ADDR[BANK_AW-1:0];
  assign MEM_DIN  = REQ_WDATA;
  assign MEM_BM   = REQ_BM;
  assign MEM_WEN  = accept && REQ_WE;
  assign MEM_REN  = accept && !REQ_WE;

  // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
  always_comb begin
    MEM_MEN = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      MEM_MEN[b] = accept && (bank == BANK_SW'(b));
    end
  end

`ifdef SRAM_REQ_CTRL_WRITE_ACK_EN
  assign rsp_accept = accept;

  always_ff @(posedge CLK) begin
    if (RST)             pend_write <= 1'b0;
    else if (rsp_accept) pend_write <= REQ_WE;
  end
`else
  assign rsp_accept = accept && !REQ_WE;
  assign pend_write = 1'b0;
`endif

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight  <= 1'b0;
      pend_bank <= '0;
      pend_err  <= 1'b0;
    end else begin
      inflight <= rsp_accept;
      if (rsp_accept) begin
        pend_bank <= bank;
        pend_err  <= !in_range;
      end
    end
  end

  // Macro output is valid the cycle after the strobe; capture the addressed bank's slice.
  always_comb begin
    bank_dout = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (pend_bank == BANK_SW'(b)) bank_dout = MEM_DOUT[b*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    push_rsp.rdata = (pend_err || pend_write) ? '0 : bank_dout;
    push_rsp.err   = pend_err;
    push_rsp.write = pend_write;
  end

  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .OCC_W (OCC_W)
  ) u_rsp_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (inflight),
    .push_data (push_rsp),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occ       (occ)
  );

  assign RSP_VALID = !RST && !fifo_empty;
  assign pop       = RSP_VALID && RSP_READY;
  assign RSP_RDATA = RSP_VALID ? head.rdata : '0;
  assign RSP_ERR   = RSP_VALID && head.err;
  // The write field is constant 0 unless write acks are enabled.
  assign RSP_WRITE = RSP_VALID && head.write;

  // Admission control reserves a slot for every in-flight response.
  a_no_overflow : assert property (@(posedge CLK) disable iff (RST) inflight |-> (!fifo_full || pop));

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed self-checking bench for sram_req_ctrl (2-bank instance with SRAM model, 3-bank instance for range errors).
// Build with +define+SRAM_REQ_CTRL_WRITE_ACK_EN to exercise write acknowledgements.
module tb_sram_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [11:0] req_addr;
  logic [31:0] req_bm;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        req_ready, rsp_valid, rsp_err, rsp_write, mem_wen, mem_ren;
  logic [31:0] rsp_rdata, mem_din, mem_bm;
  logic [9:0]  mem_addr;
  logic [1:0]  mem_men;
  logic [63:0] mem_dout;

  logic        req_ready_3, rsp_valid_3, rsp_err_3, rsp_write_3, mem_wen_3, mem_ren_3;
  logic [31:0] rsp_rdata_3, mem_din_3, mem_bm_3;
  logic [9:0]  mem_addr_3;
  logic [2:0]  mem_men_3;
  logic [95:0] mem_dout_3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sram_req_ctrl #(.NUM_BANKS(2)) dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
    .REQ_ADDR(req_addr[10:0]), .REQ_BM(req_bm), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .RSP_WRITE(rsp_write), .MEM_ADDR(mem_addr), .MEM_DIN(mem_din), .MEM_BM(mem_bm),
    .MEM_WEN(mem_wen), .MEM_REN(mem_ren), .MEM_MEN(mem_men), .MEM_DOUT(mem_dout)
  );

  sram_req_ctrl #(.NUM_BANKS(3)) dut3 (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready_3), .REQ_WE(req_we),
    .REQ_ADDR(req_addr), .REQ_BM(req_bm), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid_3), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata_3), .RSP_ERR(rsp_err_3),
    .RSP_WRITE(rsp_write_3), .MEM_ADDR(mem_addr_3), .MEM_DIN(mem_din_3), .MEM_BM(mem_bm_3),
    .MEM_WEN(mem_wen_3), .MEM_REN(mem_ren_3), .MEM_MEN(mem_men_3), .MEM_DOUT(mem_dout_3)
  );

  assign mem_dout_3 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

  // Behavioural model of two 1024x32 macros with bit-masked writes and 1-cycle read latency.
  logic [31:0] sram [2][1024];
  logic [31:0] dout_q [2];
  assign mem_dout = {dout_q[1], dout_q[0]};

  function automatic logic [31:0] pat(input int b, input logic [9:0] a);
    return {8'hA5, 8'(b), 6'd0, a};
  endfunction

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 1024; a++) sram[b][a] <= pat(b, 10'(a));
  end

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (mem_men[b]) begin
        if (mem_wen) sram[b][mem_addr] <= (sram[b][mem_addr] & ~mem_bm) | (mem_din & mem_bm);
        if (mem_ren) dout_q[b] <= sram[b][mem_addr];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and hold it until accepted (bounded).
  task automatic send(input logic we, input logic [11:0] addr, input logic [31:0] bm, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_bm = bm; req_wdata = wd;
    #1;
    for (int k = 0; k < 20 && !req_ready; k++) begin
      tick();
      #1;
    end
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL send_accept: addr %h not accepted, ready=%b want 1", addr, req_ready);
    else n_pass++;
    tick();
    req_valid = 1'b0;
  endtask

  logic [31:0] got_data [32];
  logic        got_err [32];
  logic        got_write [32];
  int          got_cnt;

  task automatic collect(input int n, input int budget);
    rsp_ready = 1'b1;
    got_cnt = 0;
    for (int c = 0; c < budget && got_cnt < n; c++) begin
      #1;
      if (rsp_valid) begin
        got_data[got_cnt] = rsp_rdata; got_err[got_cnt] = rsp_err; got_write[got_cnt] = rsp_write;
        got_cnt++;
      end
      tick();
    end
  endtask

  int acc_cyc [32];
  int rsp_cyc [32];
  logic [31:0] rsp_data [32];
  logic rdy_at [64];
  int acc_cnt;
  int rsp_cnt;

  // Stream n reads (alternating banks) with RSP_READY held low for the first `hold` cycles.
  task automatic stream(input int n, input int hold, input logic [9:0] base);
    int idx = 0;
    acc_cnt = 0;
    rsp_cnt = 0;
    for (int c = 0; c < 64 && rsp_cnt < n; c++) begin
      req_valid = (idx < n);
      req_we    = 1'b0;
      req_addr  = {1'b0, idx[0], base + 10'(idx)};
      rsp_ready = (c >= hold);
      #1;
      rdy_at[c] = req_ready;
      if (req_valid && req_ready) begin
        acc_cyc[idx] = c;
        idx++;
        acc_cnt++;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_data[rsp_cnt] = rsp_rdata;
        rsp_cyc[rsp_cnt]  = c;
        rsp_cnt++;
      end
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h405;
    req_bm = '1; req_wdata = 32'h1234_5678; rsp_ready = 1'b1;
    repeat (3) tick();
    n_checks++; if (req_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (mem_men !== 2'b00) $display("FAIL rst_men: got %b want 00", mem_men); else n_pass++;
    n_checks++; if (mem_ren !== 1'b0) $display("FAIL rst_ren: got %b want 0", mem_ren); else n_pass++;
    n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", rsp_rdata); else n_pass++;
    n_checks++; if (mem_men_3 !== 3'b000) $display("FAIL rst_men3: got %b want 000", mem_men_3); else n_pass++;
    rst = 1'b0; req_valid = 1'b0;
    tick();
    n_checks++; if (req_ready !== 1'b1) $display("FAIL post_rst_ready: got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_write_read();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h405; req_wdata = 32'hDEAD_BEEF; req_bm = '1;
    #1;
    n_checks++; if (mem_men !== 2'b10) $display("FAIL wr_men: got %b want 10", mem_men); else n_pass++;
    n_checks++; if (mem_wen !== 1'b1 || mem_ren !== 1'b0) $display("FAIL wr_strobes: wen=%b ren=%b want 1/0", mem_wen, mem_ren); else n_pass++;
    n_checks++; if (mem_addr !== 10'h005) $display("FAIL wr_addr: got %h want 005", mem_addr); else n_pass++;
    n_checks++; if (mem_din !== 32'hDEAD_BEEF) $display("FAIL wr_din: got %h want deadbeef", mem_din); else n_pass++;
    tick();
    req_valid = 1'b0;
    tick();
    #1;
`ifdef SRAM_REQ_CTRL_WRITE_ACK_EN
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL wr_ack_valid: got %b want 1", rsp_valid); else n_pass++;
    n_checks++; if (rsp_write !== 1'b1) $display("FAIL wr_ack_write: got %b want 1", rsp_write); else n_pass++;
`else
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL wr_no_rsp: got %b want 0", rsp_valid); else n_pass++;
`endif
    tick();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h405;
    #1;
    n_checks++; if (mem_men !== 2'b10) $display("FAIL rd_men: got %b want 10", mem_men); else n_pass++;
    n_checks++; if (mem_ren !== 1'b1 || mem_wen !== 1'b0) $display("FAIL rd_strobes: ren=%b wen=%b want 1/0", mem_ren, mem_wen); else n_pass++;
    n_checks++; if (mem_addr !== 10'h005) $display("FAIL rd_addr: got %h want 005", mem_addr); else n_pass++;
    tick();
    req_valid = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rd_lat1: rsp_valid got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (mem_men !== 2'b00) $display("FAIL idle_men: got %b want 00", mem_men); else n_pass++;
    tick();
    #1;
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL rd_lat2: rsp_valid got %b want 1", rsp_valid); else n_pass++;
    n_checks++; if (rsp_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h want deadbeef", rsp_rdata); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0 || rsp_write !== 1'b0) $display("FAIL rd_flags: err=%b write=%b want 0/0", rsp_err, rsp_write); else n_pass++;
    tick();
    #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rd_drained: rsp_valid got %b want 0", rsp_valid); else n_pass++;
    tick();
  endtask

  task automatic test_bitmask();
    int nexp;
`ifdef SRAM_REQ_CTRL_WRITE_ACK_EN
    nexp = 3;
`else
    nexp = 1;
`endif
    rsp_ready = 1'b0;
    send(1'b1, 12'h123, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(1'b1, 12'h123, 32'h0000_FFFF, 32'h0000_0000);
    send(1'b0, 12'h123, 32'hFFFF_FFFF, 32'h0);
    collect(nexp, 20);
    n_checks++; if (got_cnt !== nexp) $display("FAIL bm_count: got %0d want %0d", got_cnt, nexp); else n_pass++;
    if (got_cnt == nexp) begin
      n_checks++; if (got_data[nexp-1] !== 32'hFFFF_0000) $display("FAIL bm_data: got %h want ffff0000", got_data[nexp-1]); else n_pass++;
      n_checks++; if (got_err[nexp-1] !== 1'b0 || got_write[nexp-1] !== 1'b0) $display("FAIL bm_flags: err=%b write=%b want 0/0", got_err[nexp-1], got_write[nexp-1]); else n_pass++;
      for (int i = 0; i < nexp - 1; i++) begin
        n_checks++;
        if (got_write[i] !== 1'b1 || got_data[i] !== 32'h0) $display("FAIL bm_ack%0d: write=%b data=%h want 1/0", i, got_write[i], got_data[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    stream(6, 6, 10'h040);
    n_checks++; if (rdy_at[3] !== 1'b0) $display("FAIL bp_ready_drop: ready at cycle 3 got %b want 0", rdy_at[3]); else n_pass++;
    n_checks++; if (acc_cyc[2] !== 2) $display("FAIL bp_acc2: cycle got %0d want 2", acc_cyc[2]); else n_pass++;
    n_checks++; if (rdy_at[6] !== 1'b0) $display("FAIL bp_same_cycle_pop: ready at cycle 6 got %b want 0", rdy_at[6]); else n_pass++;
    n_checks++; if (acc_cyc[3] !== 7) $display("FAIL bp_acc3: cycle got %0d want 7", acc_cyc[3]); else n_pass++;
    n_checks++; if (rsp_cnt !== 6) $display("FAIL bp_count: got %0d want 6", rsp_cnt); else n_pass++;
    n_checks++; if (rsp_cyc[0] !== 6) $display("FAIL bp_first_rsp: cycle got %0d want 6", rsp_cyc[0]); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (rsp_data[i] !== pat(i % 2, 10'h040 + 10'(i))) $display("FAIL bp_data%0d: got %h want %h", i, rsp_data[i], pat(i % 2, 10'h040 + 10'(i)));
      else n_pass++;
    end
    repeat (3) tick();
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_no_dup: rsp_valid got %b want 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    stream(16, 0, 10'h080);
    n_checks++; if (acc_cyc[15] !== 15) $display("FAIL s_acc15: cycle got %0d want 15", acc_cyc[15]); else n_pass++;
    n_checks++; if (rsp_cnt !== 16) $display("FAIL s_count: got %0d want 16", rsp_cnt); else n_pass++;
    n_checks++; if (rsp_cyc[0] !== 2) $display("FAIL s_first_rsp: cycle got %0d want 2", rsp_cyc[0]); else n_pass++;
    n_checks++; if (rsp_cyc[15] !== 17) $display("FAIL s_last_rsp: cycle got %0d want 17", rsp_cyc[15]); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (rsp_data[i] !== pat(i % 2, 10'h080 + 10'(i))) $display("FAIL s_data%0d: got %h want %h", i, rsp_data[i], pat(i % 2, 10'h080 + 10'(i)));
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_out_of_range();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'hC00; req_bm = '0; req_wdata = 32'hCAFE_F00D;
    #1;
    n_checks++; if (mem_men_3 !== 3'b000) $display("FAIL oor_rd_men: got %b want 000", mem_men_3); else n_pass++;
    tick();
    req_valid = 1'b0;
    tick();
    #1;
    n_checks++; if (rsp_valid_3 !== 1'b1) $display("FAIL oor_rd_valid: got %b want 1", rsp_valid_3); else n_pass++;
    n_checks++; if (rsp_err_3 !== 1'b1) $display("FAIL oor_rd_err: got %b want 1", rsp_err_3); else n_pass++;
    n_checks++; if (rsp_rdata_3 !== 32'h0) $display("FAIL oor_rd_data: got %h want 0", rsp_rdata_3); else n_pass++;
    tick();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h800;
    #1;
    n_checks++; if (mem_men_3 !== 3'b100) $display("FAIL b2_men: got %b want 100", mem_men_3); else n_pass++;
    tick();
    req_valid = 1'b0;
    tick();
    #1;
    n_checks++; if (rsp_rdata_3 !== 32'h3333_3333 || rsp_err_3 !== 1'b0) $display("FAIL b2_rsp: data=%h err=%b want 33333333/0", rsp_rdata_3, rsp_err_3); else n_pass++;
    tick();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 12'hC00;
    #1;
    n_checks++; if (mem_men_3 !== 3'b000 || mem_wen_3 !== 1'b1) $display("FAIL oor_wr_strobes: men=%b wen=%b want 000/1", mem_men_3, mem_wen_3); else n_pass++;
    tick();
    req_valid = 1'b0;
    tick();
    #1;
`ifdef SRAM_REQ_CTRL_WRITE_ACK_EN
    n_checks++; if (rsp_valid_3 !== 1'b1) $display("FAIL oor_wr_ack: valid got %b want 1", rsp_valid_3); else n_pass++;
    n_checks++; if (rsp_write_3 !== 1'b1 || rsp_err_3 !== 1'b1) $display("FAIL oor_wr_flags: write=%b err=%b want 1/1", rsp_write_3, rsp_err_3); else n_pass++;
    n_checks++; if (rsp_rdata_3 !== 32'h0) $display("FAIL oor_wr_data: got %h want 0", rsp_rdata_3); else n_pass++;
`else
    n_checks++; if (rsp_valid_3 !== 1'b0) $display("FAIL oor_wr_dropped: valid got %b want 0", rsp_valid_3); else n_pass++;
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h0A0 + 12'(i);
      tick();
    end
    req_valid = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL mid_pending: rsp_valid got %b want 1", rsp_valid); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) $display("FAIL mid_in_rst: valid=%b ready=%b want 0/0", rsp_valid, req_ready); else n_pass++;
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 6; c++) begin
        #1;
        if (rsp_valid) seen++;
        tick();
      end
      n_checks++; if (seen !== 0) $display("FAIL mid_discard: responses after reset got %0d want 0", seen); else n_pass++;
    end
    n_checks++; if (req_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", req_ready); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bitmask();
    test_backpressure();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
